// File: rtl/cpu6502_pkg.sv
// rtl/cpu6502_pkg.sv - shared 6502 control constants, step encodings and interrupt source types
package cpu6502_pkg;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RST = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  localparam logic [2:0] STEP_BRK = 3'd0;
  localparam logic [2:0] STEP_PCH = 3'd2;
  localparam logic [2:0] STEP_PCL = 3'd3;
  localparam logic [2:0] STEP_P   = 3'd4;
  localparam logic [2:0] STEP_VL  = 3'd5;
  localparam logic [2:0] STEP_VH  = 3'd6;

  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_IRQ
  } src_e;

  typedef enum logic {
    ST_IDLE,
    ST_SEQ
  } seq_state_e;

  // Low byte of the vector fetched for a given interrupt source
  function automatic logic [7:0] src_vector(input src_e src);
    logic [7:0] vec;
    case (src)
      SRC_RST: vec = VEC_RST;
      SRC_NMI: vec = VEC_NMI;
      default: vec = VEC_IRQ;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// rtl/nmi_edge_detect.sv - tick-qualified rising-edge latch with clear
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  input  logic clear,
  output logic rise,
  output logic pending
);

  logic prev;

  // A rise is only recognised on a tick so the detector freezes with the CPU
  assign rise = tick & din & ~prev;

  // History and latched request; clear wins so an edge consumed this tick is not re-latched
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (tick) begin
        prev <= din;
      end
      if (clear) begin
        pending <= 1'b0;
      end else if (rise) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - resolves RESET/NMI/IRQ and sequences the 7-cycle forced-BRK entry
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [1:0] InputInvertMask = 2'b11,
  parameter int         SeqLength       = 7
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       NmiIn,
  input  logic       IrqIn,
  input  logic       IFlag,
  input  logic       Sync,
  output logic       Take,
  output logic [2:0] Step,
  output logic       PushEn,
  output logic       PushRead,
  output logic       BFlagOut,
  output logic       SetIFlag,
  output logic [7:0] VectorLow,
  output logic       Busy
);

  // The step encodings and strobes below assume the standard 7-cycle entry
  generate
    if (SeqLength != 7) begin : g_bad_seq_length
      $error("interrupt_sequencer: SeqLength must be 7");
    end
  endgenerate

  seq_state_e state, state_n;
  logic [2:0] step, step_n;
  src_e       src, src_n;
  logic       rst_pending, rst_pending_n;
  logic       irq_pending;
  logic       nmi_rise, nmi_pending, nmi_clear, nmi_req;
  logic       nmi_eff, irq_eff;

  assign nmi_eff = NmiIn ^ InputInvertMask[0];
  assign irq_eff = IrqIn ^ InputInvertMask[1];

  nmi_edge_detect u_nmi_edge (
    .clk     (Clock),
    .rst     (Reset),
    .tick    (Tick),
    .din     (nmi_eff),
    .clear   (nmi_clear),
    .rise    (nmi_rise),
    .pending (nmi_pending)
  );

  // An edge arriving in the same tick as the decision point is already eligible
  assign nmi_req = nmi_pending | nmi_rise;

  // State register plus the level-sampled IRQ request
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      step        <= STEP_BRK;
      src         <= SRC_RST;
      rst_pending <= 1'b1;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      src         <= src_n;
      rst_pending <= rst_pending_n;
      if (Tick) begin
        irq_pending <= irq_eff & ~IFlag;
      end
    end
  end

  // Next-state: entry at an instruction boundary, stepping, and NMI hijack of an IRQ entry
  always_comb begin
    state_n       = state;
    step_n        = step;
    src_n         = src;
    rst_pending_n = rst_pending;
    nmi_clear     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Tick && Sync && (rst_pending || nmi_req || irq_pending)) begin
          state_n = ST_SEQ;
          step_n  = STEP_BRK;
          if (rst_pending) begin
            src_n         = SRC_RST;
            rst_pending_n = 1'b0;
          end else if (nmi_req) begin
            src_n     = SRC_NMI;
            nmi_clear = 1'b1;
          end else begin
            src_n = SRC_IRQ;
          end
        end
      end
      ST_SEQ: begin
        if (Tick) begin
          if (step == STEP_VH) begin
            state_n = ST_IDLE;
            step_n  = STEP_BRK;
          end else begin
            step_n = step + 3'd1;
          end
          // Before the vector fetch an NMI can still redirect an IRQ entry
          if (src == SRC_IRQ && step <= STEP_P && nmi_req) begin
            src_n     = SRC_NMI;
            nmi_clear = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        step_n  = STEP_BRK;
      end
    endcase
  end

  // Outputs decoded from the registered state so they hold while Tick is low
  always_comb begin
    Busy      = (state == ST_SEQ);
    Take      = Busy;
    Step      = step;
    PushEn    = Busy && (step >= STEP_PCH) && (step <= STEP_P);
    PushRead  = PushEn && (src == SRC_RST);
    BFlagOut  = 1'b0;
    SetIFlag  = Busy && (step == STEP_VL);
    VectorLow = src_vector(src);
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed table-driven bench for interrupt_sequencer
module tb_interrupt_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b1;
  logic       NmiIn = 1'b1;
  logic       IrqIn = 1'b1;
  logic       IFlag = 1'b1;
  logic       Sync = 1'b0;
  logic       Take;
  logic [2:0] Step;
  logic       PushEn;
  logic       PushRead;
  logic       BFlagOut;
  logic       SetIFlag;
  logic [7:0] VectorLow;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tick      (Tick),
    .NmiIn     (NmiIn),
    .IrqIn     (IrqIn),
    .IFlag     (IFlag),
    .Sync      (Sync),
    .Take      (Take),
    .Step      (Step),
    .PushEn    (PushEn),
    .PushRead  (PushRead),
    .BFlagOut  (BFlagOut),
    .SetIFlag  (SetIFlag),
    .VectorLow (VectorLow),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  // pins = {Reset, Tick, NmiIn, IrqIn, IFlag, Sync}
  // exp  = {Take, Step, PushEn, PushRead, BFlagOut, SetIFlag, VectorLow, Busy}
  typedef struct {
    string       name;
    logic [5:0]  pins;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] idle(input logic [7:0] vl);
    return {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, vl, 1'b0};
  endfunction

  function automatic logic [16:0] seq(input int s, input logic is_rst, input logic [7:0] vl);
    logic [2:0] st;
    logic       pe;
    st = 3'(s);
    pe = (s >= 2) && (s <= 4);
    return {1'b1, st, pe, pe & is_rst, 1'b0, (s == 5), vl, 1'b1};
  endfunction

  function automatic vec_t mk(input string name, input logic [5:0] pins, input logic [16:0] exp);
    vec_t v;
    v.name = name;
    v.pins = pins;
    v.exp  = exp;
    return v;
  endfunction

  task automatic run(input string name, input logic [5:0] pins, input logic [16:0] exp);
    logic [16:0] got;
    {Reset, Tick, NmiIn, IrqIn, IFlag, Sync} = pins;
    @(posedge Clock);
    #1;
    got = {Take, Step, PushEn, PushRead, BFlagOut, SetIFlag, VectorLow, Busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (take step pe pr b si vl busy)", name, got, exp);
    end
  endtask

  // IRQ entry up to and including the given step; IRQ released after entry
  task automatic irq_enter(input logic [7:0] idle_vl, input int upto);
    run("irq_arm", 6'b011000, idle(idle_vl));
    run("irq_take", 6'b011001, seq(0, 1'b0, 8'hFE));
    for (int s = 1; s <= upto; s++) begin
      run("irq_step", 6'b011100, seq(s, 1'b0, 8'hFE));
    end
  endtask

  initial begin
    // Reset sequence
    tbl.push_back(mk("reset", 6'b111110, idle(8'hFC)));
    tbl.push_back(mk("rst_take", 6'b011111, seq(0, 1'b1, 8'hFC)));
    for (int s = 1; s <= 6; s++) tbl.push_back(mk("rst_step", 6'b011110, seq(s, 1'b1, 8'hFC)));
    tbl.push_back(mk("rst_done", 6'b011110, idle(8'hFC)));
    // IRQ path
    tbl.push_back(mk("irq_arm", 6'b011000, idle(8'hFC)));
    tbl.push_back(mk("irq_take", 6'b011001, seq(0, 1'b0, 8'hFE)));
    for (int s = 1; s <= 6; s++) tbl.push_back(mk("irq_step", 6'b011100, seq(s, 1'b0, 8'hFE)));
    tbl.push_back(mk("irq_done", 6'b011100, idle(8'hFE)));
    // IRQ masked by I flag
    tbl.push_back(mk("irq_masked_arm", 6'b011010, idle(8'hFE)));
    tbl.push_back(mk("irq_masked_sync", 6'b011011, idle(8'hFE)));
    tbl.push_back(mk("irq_masked_rel", 6'b011111, idle(8'hFE)));
    // IRQ withdrawn before the boundary is lost
    tbl.push_back(mk("irq_wd_arm", 6'b011000, idle(8'hFE)));
    tbl.push_back(mk("irq_wd_drop", 6'b011100, idle(8'hFE)));
    tbl.push_back(mk("irq_wd_sync", 6'b011101, idle(8'hFE)));
    // NMI held active for 20 ticks across two boundaries
    tbl.push_back(mk("nmi_edge", 6'b010110, idle(8'hFE)));
    tbl.push_back(mk("nmi_take", 6'b010111, seq(0, 1'b0, 8'hFA)));
    for (int s = 1; s <= 6; s++) tbl.push_back(mk("nmi_step", 6'b010110, seq(s, 1'b0, 8'hFA)));
    tbl.push_back(mk("nmi_done", 6'b010110, idle(8'hFA)));
    for (int i = 0; i < 10; i++) tbl.push_back(mk("nmi_held", 6'b010110, idle(8'hFA)));
    tbl.push_back(mk("nmi_held_sync", 6'b010111, idle(8'hFA)));
    tbl.push_back(mk("nmi_release", 6'b011110, idle(8'hFA)));
    // NMI pulse entirely within Tick-low cycles is not seen
    tbl.push_back(mk("nmi_notick_lo", 6'b000110, idle(8'hFA)));
    tbl.push_back(mk("nmi_notick_hi", 6'b001110, idle(8'hFA)));
    tbl.push_back(mk("nmi_notick_sync", 6'b011111, idle(8'hFA)));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].name, tbl[i].pins, tbl[i].exp);
    end

    // NMI edge at IRQ step 3 hijacks the vector; no second NMI entry afterwards
    irq_enter(8'hFA, 3);
    run("hj3_step4", 6'b010100, seq(4, 1'b0, 8'hFA));
    run("hj3_step5", 6'b010100, seq(5, 1'b0, 8'hFA));
    run("hj3_step6", 6'b010100, seq(6, 1'b0, 8'hFA));
    run("hj3_done", 6'b010100, idle(8'hFA));
    run("hj3_sync", 6'b010101, idle(8'hFA));
    run("hj3_release", 6'b011100, idle(8'hFA));

    // NMI edge at step 5 is too late: IRQ vector kept, NMI taken at next boundary
    irq_enter(8'hFA, 5);
    run("hj5_step6", 6'b010100, seq(6, 1'b0, 8'hFE));
    run("hj5_done", 6'b010100, idle(8'hFE));
    run("hj5_nmi_take", 6'b010101, seq(0, 1'b0, 8'hFA));
    for (int s = 1; s <= 6; s++) run("hj5_nmi_step", 6'b010100, seq(s, 1'b0, 8'hFA));
    run("hj5_nmi_done", 6'b011100, idle(8'hFA));

    // Reset at step 3 aborts the IRQ entry even with Tick low, then RESET runs
    irq_enter(8'hFA, 3);
    run("abort_reset", 6'b101100, idle(8'hFC));
    run("abort_rst_take", 6'b011101, seq(0, 1'b1, 8'hFC));
    for (int s = 1; s <= 6; s++) run("abort_rst_step", 6'b011100, seq(s, 1'b1, 8'hFC));
    run("abort_rst_done", 6'b011100, idle(8'hFC));

    // Tick low for 5 cycles at step 2 freezes everything
    irq_enter(8'hFC, 2);
    for (int i = 0; i < 5; i++) run("freeze", 6'b001101, seq(2, 1'b0, 8'hFE));
    for (int s = 3; s <= 6; s++) run("resume_step", 6'b011100, seq(s, 1'b0, 8'hFE));
    run("resume_done", 6'b011110, idle(8'hFE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sits between the interrupt request gating and the 6502 core control logic.
- The gating ORs interrupt sources into single request lines. This block does the reverse: it resolves RESET, NMI and IRQ requests and decides which one is taken.
- It sequences the 7-cycle interrupt entry (forced BRK) and supplies the control strobes and vector address low byte to the datapath.
- Stepping is qualified by the CPU phase tick, so the block runs on the single system clock.

Parameters:
- InputInvertMask, 3, bit0 inverts NmiIn and bit1 inverts IrqIn. The default makes both pins active-low. Internal "effective" signals are active-high.
- SeqLength, 7, number of cycles in the entry sequence. Fixed at 7; any other value is rejected by a generate-time check.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous active-high reset.
- Tick  in  1  CPU cycle enable. State advances only when Tick=1.
- NmiIn  in  1  NMI request pin (polarity set by mask).
- IrqIn  in  1  IRQ request pin, level-sensitive (polarity set by mask).
- IFlag  in  1  processor status I bit.
- Sync  in  1  opcode-fetch cycle marker (instruction boundary).
- Take  out  1  forces BRK ($00) into IR; high for the whole sequence.
- Step  out  3  sequence step 0..6; 0 when idle.
- PushEn  out  1  stack write strobe, asserted at steps 2, 3, 4.
- PushRead  out  1  converts pushes into reads (reset sequence only).
- BFlagOut  out  1  B bit written into the pushed P. 0 for hardware interrupts.
- SetIFlag  out  1  one-cycle strobe at step 5.
- VectorLow  out  8  $FA NMI, $FC RESET, $FE IRQ; valid at steps 5 and 6.
- Busy  out  1  high while the sequence is active.

Behaviour:
- **Reset**, applied on any edge with Reset=1 regardless of Tick:
  - State returns to IDLE.
  - All outputs go to 0, except VectorLow=$FC.
  - nmi_pending, nmi_prev and irq_pending are cleared; rst_pending is set.
  - A reset mid-sequence aborts the sequence immediately, with no partial pushes afterwards.
- **NMI edge detection** (on Tick):
  - nmi_prev is updated from effective NMI.
  - A 0->1 transition of effective NMI sets nmi_pending.
  - A held-high NMI produces exactly one request.
- **IRQ**: irq_pending is re-sampled every Tick as effective IRQ AND NOT IFlag. There is no latching, so a request withdrawn before Sync is lost.
- **States**: IDLE and SEQ.
- **IDLE -> SEQ** on Tick & Sync when (rst_pending | nmi_pending | irq_pending).
  - Source is latched with priority RESET > NMI > IRQ.
  - Step=0 and Take=1 in the cycle of entry.
  - The latched source's pending flag is cleared, except irq_pending, which keeps tracking the pin.
- **SEQ**: Step increments by 1 on each Tick.
  - On the Tick at Step=6, the block returns to IDLE, Step=0, Take=0, Busy=0.
- **Step meanings**:
  - 0: forced BRK fetch. PC increment is suppressed by the core via Take.
  - 1: dummy read.
  - 2: PCH push.
  - 3: PCL push.
  - 4: P push.
  - 5: vector low fetch, SetIFlag=1.
  - 6: vector high fetch.
- **RESET source**: PushEn and PushRead are both asserted at steps 2-4 (stack pointer still decrements, but no write).
- **NMI hijack**: if an NMI edge arrives while sequencing IRQ at Step <= 4:
  - The source switches to NMI and VectorLow becomes $FA from step 5.
  - nmi_pending is cleared.
  - At Step >= 5 the NMI stays pending for the next boundary.
- **Simultaneous events**:
  - Sync and an NMI edge in the same Tick: the NMI is eligible that cycle.
  - Reset overrides everything.
- **Tick low**: all state and outputs hold, including the edge detector.

Decomposition:
- Shared package (cpu6502_pkg) holds:
  - vector constants VEC_NMI=$FA, VEC_RST=$FC, VEC_IRQ=$FE;
  - step encodings STEP_PCH=2, STEP_PCL=3, STEP_P=4, STEP_VL=5, STEP_VH=6;
  - the source enum {SRC_RST, SRC_NMI, SRC_IRQ}.
- One sub-module, nmi_edge_detect: Tick-qualified rising-edge latch with a clear input, reused for the SO pin later.

Test Plan:
- **Reset, then Sync pulse with Tick every cycle**:
  - Take=1 for 7 ticks.
  - PushEn=PushRead=1 at steps 2-4.
  - VectorLow=$FC at steps 5-6.
  - Busy drops after step 6.
- **IRQ path**: IrqIn=0 (active), IFlag=0, Sync.
  - Sequence runs with BFlagOut=0, PushRead=0, VectorLow=$FE, SetIFlag pulse at step 5.
  - Repeat with IFlag=1: Take stays 0.
- **NMI held low for 20 ticks across two Sync pulses**: exactly one sequence with VectorLow=$FA; the second Sync gives no Take.
- **NMI hijack**:
  - NMI edge at IRQ step 3: VectorLow=$FA at step 5, and no further NMI sequence afterwards.
  - NMI edge at step 5: vector $FE, then an NMI sequence at the next Sync.
- **Reset asserted at step 3 of an IRQ sequence**: next edge gives Busy=0, Step=0, PushEn=0; the following Sync runs the RESET sequence.
- **Tick low for 5 cycles at step 2**: Step and outputs frozen, and the sequence resumes at step 3 on the next Tick.
